alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (power of two, 32 or 64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port alu_op  input  2  00 I-type, 01 add (load/store address), 10 R-type, 11 branch.
REQ-007 SHALL have port funct3  input  3  and port funct7  input  7  instruction fields.
REQ-008 SHALL have ports op_a, op_b  input  XLEN  source operands.
REQ-009 SHALL have port out_valid  output  1  and port out_ready  input  1  result handshake.
REQ-010 SHALL have port result  output  XLEN  registered result.
REQ-011 SHALL have port branch_taken  output  1  registered branch outcome (alu_op 11 only, else 0).
REQ-012 SHALL have port illegal  output  1  registered flag: unsupported funct3/funct7 combination.

Function
REQ-013 SHALL transfer a request when in_valid && in_ready; SHALL transfer a result when out_valid && out_ready.
REQ-014 SHALL implement states IDLE, ITER, HOLD; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-015 Single-cycle ops: SHALL register result/branch_taken/illegal on the accept edge and assert out_valid the following cycle (latency 1).
REQ-016 SHALL hold result, branch_taken, illegal, out_valid stable while out_valid && !out_ready (state HOLD for iterative ops).
REQ-017 R-type (alu_op 10, funct7 0000000/0100000): ADD, SUB (f7[5]=1, f3 000), SLL, SLT, SLTU, XOR, SRL, SRA (f7[5]=1, f3 101), OR, AND.
REQ-018 I-type (alu_op 00): ADDI, SLTI, SLTIU, XORI, ORI, ANDI ignore funct7; f3 101 SHALL select SRAI when funct7[5]=1, else SRLI; SLLI on f3 001.
REQ-019 Shift amount SHALL be op_b[$clog2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN; SLT signed, SLTU unsigned, result 1 or 0.
REQ-020 alu_op 01 SHALL produce op_a+op_b regardless of funct fields.
REQ-021 Branch (alu_op 11): f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU -> branch_taken; result = 0; f3 010/011 SHALL set illegal.
REQ-022 Any unlisted encoding SHALL complete in 1 cycle with result 0, branch_taken 0, illegal 1.
REQ-023 Back-to-back single-cycle requests SHALL sustain one result per cycle while out_ready=1.

Reset
REQ-024 On rst: state IDLE, out_valid 0, result 0, branch_taken 0, illegal 0, iteration counter 0; in_ready SHALL read 1 while rst is low after reset.
REQ-025 rst asserted mid-iteration SHALL abort the operation; no result emitted.

Configuration
REQ-026 Macro ALU_EXEC_MEXT_EN defined: alu_op 10 with funct7 0000001 SHALL execute MUL (f3 000), DIV (100), DIVU (101), REM (110), REMU (111) iteratively in state ITER, out_valid asserted exactly XLEN+1 cycles after accept; other f3 -> illegal per REQ-022.
REQ-027 Divide by zero: quotient all-ones, remainder = op_a; signed overflow (MIN / -1): quotient MIN, remainder 0; both still take XLEN+1 cycles.
REQ-028 Macro undefined: funct7 0000001 SHALL be illegal (REQ-022); ITER state and multiplier/divider logic absent.

Structure
REQ-029 Shared package alu_pkg SHALL hold alu_op encodings, funct3/funct7 constants, internal op enumeration, state enumeration.
REQ-030 Iterative shift-add multiplier / restoring divider SHALL be sub-module alu_muldiv_iter, instantiated only under ALU_EXEC_MEXT_EN.

Verification
REQ-031 XLEN=32, alu_op 10, f3 000, f7 0100000, a=5, b=7 -> next cycle out_valid=1, result=0xFFFFFFFE, illegal=0.
REQ-032 alu_op 00, f3 101, f7 0100000, a=0x80000000, b=4 -> result 0xF8000000; same with f7 0 -> 0x08000000.
REQ-033 alu_op 11, f3 100, a=0xFFFFFFFF, b=1 -> branch_taken=1; f3 110 same operands -> branch_taken=0.
REQ-034 out_ready held 0 for 3 cycles after result -> result and out_valid stable, in_ready=0; release -> transfer, in_ready=1 same cycle.
REQ-035 MEXT_EN: DIV a=7, b=0 -> result 0xFFFFFFFF after exactly 33 cycles; REM a=0x80000000, b=0xFFFFFFFF -> result 0.
REQ-036 rst pulsed during MUL iteration -> out_valid 0, state IDLE, no result after reset release.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution unit: alu_op encodings, funct3 and
// funct7 field constants, the internal operation enumeration produced by the
// decoder, and the control state enumeration.
// Optional feature macro: ALU_EXEC_MEXT_EN (multiply/divide extension). The
// M-extension operations are always listed here so that the decoder and the
// iterative unit share one enumeration; they are reachable only when the
// macro is defined.
// -----------------------------------------------------------------------------
package alu_pkg;

  // alu_op encodings
  localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
  localparam logic [1:0] ALUOP_ADD    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BRANCH = 2'b11;

  // funct3 for arithmetic/logic operations
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for branch comparisons
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 for multiply/divide
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // funct7 variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_HOLD
  } state_e;

  // Operations that run through the multi-cycle multiply/divide unit
  function automatic logic isIterOp(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative shift-add multiplier and restoring divider, one bit per clock.
// A start pulse loads the operands; XLEN iterations follow, after which
// o_done is high for exactly one cycle with the final value on o_result.
// Only instantiated when ALU_EXEC_MEXT_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_start      load operands and begin (must only pulse when idle)
//   i_op         OP_MUL / OP_DIV / OP_DIVU / OP_REM / OP_REMU
//   i_a, i_b     operands (dividend/divisor for divides)
//   o_done       final value valid this cycle
//   o_result     product low half, quotient or remainder
// -----------------------------------------------------------------------------
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  op_e             i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_count;
  logic            r_isMul;
  logic            r_wantRem;
  logic            r_quoNeg;
  logic            r_remNeg;
  logic            r_divZero;
  logic [XLEN-1:0] r_origA;
  // r_acc: running product (MUL) or partial remainder (divides)
  // r_work: remaining multiplier bits (MUL) or dividend/quotient shift register
  // r_operand: shifted multiplicand (MUL) or divisor magnitude
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_work;
  logic [XLEN-1:0] r_operand;

  logic            w_signedDiv;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN:0]   w_remShift;
  logic [XLEN:0]   w_diff;

  assign w_signedDiv = (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_aNeg      = w_signedDiv && i_a[XLEN-1];
  assign w_bNeg      = w_signedDiv && i_b[XLEN-1];

  // Restoring divide step: bring down the next dividend bit and try to
  // subtract the divisor; the borrow bit decides the quotient bit.
  assign w_remShift = {r_acc, r_work[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_operand};

  // Divides run on magnitudes; signs are reapplied on the way out. The
  // MIN / -1 case needs no special handling: |MIN| / 1 leaves the MIN bit
  // pattern with a positive sign and a zero remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_isMul   <= 1'b0;
      r_wantRem <= 1'b0;
      r_quoNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divZero <= 1'b0;
      r_origA   <= '0;
      r_acc     <= '0;
      r_work    <= '0;
      r_operand <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_count   <= '0;
      r_isMul   <= (i_op == OP_MUL);
      r_wantRem <= (i_op == OP_REM) || (i_op == OP_REMU);
      r_quoNeg  <= w_aNeg ^ w_bNeg;
      r_remNeg  <= w_aNeg;
      r_divZero <= (i_b == '0);
      r_origA   <= i_a;
      r_acc     <= '0;
      if (i_op == OP_MUL) begin
        r_work    <= i_b;
        r_operand <= i_a;
      end else begin
        r_work    <= w_aNeg ? -i_a : i_a;
        r_operand <= w_bNeg ? -i_b : i_b;
      end
    end else if (r_busy) begin
      if (r_count == LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count + 1'b1;
        if (r_isMul) begin
          if (r_work[0]) begin
            r_acc <= r_acc + r_operand;
          end
          r_operand <= r_operand << 1;
          r_work    <= r_work >> 1;
        end else if (!w_diff[XLEN]) begin
          r_acc  <= w_diff[XLEN-1:0];
          r_work <= {r_work[XLEN-2:0], 1'b1};
        end else begin
          r_acc  <= w_remShift[XLEN-1:0];
          r_work <= {r_work[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign o_done = r_busy && (r_count == LAST);

  // Final value selection, including the divide-by-zero convention
  // (quotient all ones, remainder equal to the original dividend).
  always_comb begin
    o_result = r_acc;
    if (r_isMul) begin
      o_result = r_acc;
    end else if (r_divZero) begin
      o_result = r_wantRem ? r_origA : '1;
    end else if (r_wantRem) begin
      o_result = r_remNeg ? -r_acc : r_acc;
    end else begin
      o_result = r_quoNeg ? -r_work : r_work;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Integer execution unit with valid/ready handshakes on both sides. Single-
// cycle operations return their result the cycle after acceptance; with
// ALU_EXEC_MEXT_EN defined, multiply/divide run iteratively and return
// XLEN+1 cycles after acceptance. Without the macro those encodings are
// reported as illegal.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake
//   alu_op, funct3/funct7 operation selection
//   op_a, op_b            source operands
//   out_valid / out_ready result handshake
//   result                registered result
//   branch_taken          registered branch outcome (branches only)
//   illegal               registered unsupported-encoding flag
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e          r_state;
  state_e          w_nextState;
  logic            r_outValid;
  logic [XLEN-1:0] r_result;
  logic            r_taken;
  logic            r_illegal;

  op_e             w_op;
  logic [XLEN-1:0] w_aluResult;
  logic            w_taken;
  logic            w_illegal;
  logic            w_accept;
  logic            w_isIter;
  logic            w_mdDone;
  logic [XLEN-1:0] w_mdResult;
  logic [SHW-1:0]  w_shamt;

  assign in_ready     = (r_state == ST_IDLE) && (!r_outValid || out_ready);
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = r_outValid;
  assign result       = r_result;
  assign branch_taken = r_taken;
  assign illegal      = r_illegal;
  assign w_shamt      = op_b[SHW-1:0];

  // Decode alu_op/funct3/funct7 into one internal operation. I-type ignores
  // funct7 except bit 5 on the right-shift encoding.
  always_comb begin
    w_op = OP_ILLEGAL;
    unique case (alu_op)
      ALUOP_ADD: w_op = OP_ADD;
      ALUOP_ITYPE: begin
        unique case (funct3)
          F3_ADD:  w_op = OP_ADD;
          F3_SLL:  w_op = OP_SLL;
          F3_SLT:  w_op = OP_SLT;
          F3_SLTU: w_op = OP_SLTU;
          F3_XOR:  w_op = OP_XOR;
          F3_SR:   w_op = funct7[5] ? OP_SRA : OP_SRL;
          F3_OR:   w_op = OP_OR;
          F3_AND:  w_op = OP_AND;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            F3_ADD:  w_op = OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = OP_SRL;
            F3_OR:   w_op = OP_OR;
            F3_AND:  w_op = OP_AND;
            default: w_op = OP_ILLEGAL;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD) begin
            w_op = OP_SUB;
          end else if (funct3 == F3_SR) begin
            w_op = OP_SRA;
          end
`ifdef ALU_EXEC_MEXT_EN
        end else if (funct7 == F7_MEXT) begin
          unique case (funct3)
            F3_MUL:  w_op = OP_MUL;
            F3_DIV:  w_op = OP_DIV;
            F3_DIVU: w_op = OP_DIVU;
            F3_REM:  w_op = OP_REM;
            F3_REMU: w_op = OP_REMU;
            default: w_op = OP_ILLEGAL;
          endcase
`endif
        end
      end
      ALUOP_BRANCH: begin
        unique case (funct3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      default: w_op = OP_ILLEGAL;
    endcase
  end

  // Single-cycle datapath. Branches and illegal encodings produce result 0.
  always_comb begin
    w_aluResult = '0;
    w_taken     = 1'b0;
    case (w_op)
      OP_ADD:  w_aluResult = op_a + op_b;
      OP_SUB:  w_aluResult = op_a - op_b;
      OP_SLL:  w_aluResult = op_a << w_shamt;
      OP_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  w_aluResult = op_a ^ op_b;
      OP_SRL:  w_aluResult = op_a >> w_shamt;
      OP_SRA:  w_aluResult = $signed(op_a) >>> w_shamt;
      OP_OR:   w_aluResult = op_a | op_b;
      OP_AND:  w_aluResult = op_a & op_b;
      OP_BEQ:  w_taken = (op_a == op_b);
      OP_BNE:  w_taken = (op_a != op_b);
      OP_BLT:  w_taken = ($signed(op_a) < $signed(op_b));
      OP_BGE:  w_taken = ($signed(op_a) >= $signed(op_b));
      OP_BLTU: w_taken = (op_a < op_b);
      OP_BGEU: w_taken = (op_a >= op_b);
      default: begin
        w_aluResult = '0;
        w_taken     = 1'b0;
      end
    endcase
  end

  assign w_illegal = (w_op == OP_ILLEGAL);

`ifdef ALU_EXEC_MEXT_EN
  assign w_isIter = isIterOp(w_op);

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_isIter),
    .i_op     (w_op),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_done   (w_mdDone),
    .o_result (w_mdResult)
  );
`else
  assign w_isIter   = 1'b0;
  assign w_mdDone   = 1'b0;
  assign w_mdResult = '0;
`endif

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: ITER while the iterative unit works, HOLD until its result
  // is taken. Single-cycle results are held in IDLE with in_ready low.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept && w_isIter) w_nextState = ST_ITER;
      ST_ITER: if (w_mdDone) w_nextState = ST_HOLD;
      ST_HOLD: if (out_ready) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output registers. A new single-cycle result may replace one that is
  // being drained in the same cycle, which keeps back-to-back throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_taken    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept && !w_isIter) begin
      r_outValid <= 1'b1;
      r_result   <= w_aluResult;
      r_taken    <= w_taken;
      r_illegal  <= w_illegal;
    end else if ((r_state == ST_ITER) && w_mdDone) begin
      r_outValid <= 1'b1;
      r_result   <= w_mdResult;
      r_taken    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed bench for alu_exec_unit. A reference model computes each expected
// transaction from the instruction fields; a monitor compares the outputs on
// every cycle out_valid is high and checks result latency. Directed sections
// pin key values with literal expectations. Multiply/divide sections are
// compiled only when ALU_EXEC_MEXT_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;
  logic            illegal;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic        taken;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  exp_t expQ[$];
  bit   seenFront = 0;

  alu_exec_unit #(
    .XLEN(XLEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .funct3       (funct3),
    .funct7       (funct7),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the unit must return for one request
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    int     sh;
    longint sa;
    longint sb;
    bit     isR;
    bit     alt;
    e.res = 32'd0; e.taken = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0;
    sh  = int'(b[4:0]);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    isR = (op == 2'b10);
    if (op == 2'b01) begin
      e.res = a + b;
    end else if (op == 2'b11) begin
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = (sa < sb);
        3'd5: e.taken = (sa >= sb);
        3'd6: e.taken = (a < b);
        3'd7: e.taken = (a >= b);
        default: e.ill = 1'b1;
      endcase
    end else if (isR && f7 == 7'b0000001) begin
`ifdef ALU_EXEC_MEXT_EN
      e.lat = XLEN + 1;
      case (f3)
        3'd0: e.res = a * b;
        3'd4: begin
          if (b == 0) e.res = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = 32'h80000000;
          else e.res = 32'(sa / sb);
        end
        3'd5: e.res = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) e.res = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = 32'd0;
          else e.res = 32'(sa % sb);
        end
        3'd7: e.res = (b == 0) ? a : a % b;
        default: begin e.ill = 1'b1; e.lat = 1; end
      endcase
`else
      e.ill = 1'b1;
`endif
    end else if (isR && f7 != 7'b0000000 && f7 != 7'b0100000) begin
      e.ill = 1'b1;
    end else begin
      alt = isR ? (f7 == 7'b0100000) : f7[5];
      if (isR && alt && f3 != 3'd0 && f3 != 3'd5) begin
        e.ill = 1'b1;
      end else begin
        case (f3)
          3'd0: e.res = (isR && alt) ? a - b : a + b;
          3'd1: e.res = a << sh;
          3'd2: e.res = (sa < sb) ? 32'd1 : 32'd0;
          3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
          3'd4: e.res = a ^ b;
          3'd5: e.res = alt ? 32'(sa >>> sh) : a >> sh;
          3'd6: e.res = a | b;
          default: e.res = a & b;
        endcase
      end
    end
    return e;
  endfunction

  // Monitor: on every falling edge compare outputs with the oldest expected
  // transaction, check when it first appears, and record new acceptances.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      expQ.delete();
      seenFront = 0;
    end else begin
      if (out_valid) begin
        checks = checks + 1;
        if (expQ.size() == 0) begin
          errors = errors + 1;
          $display("[TB] FAIL unexpected_result actual out_valid=1 result=%h required no pending result", result);
        end else begin
          if (result !== expQ[0].res || branch_taken !== expQ[0].taken || illegal !== expQ[0].ill) begin
            errors = errors + 1;
            $display("[TB] FAIL scoreboard actual res=%h taken=%b ill=%b required res=%h taken=%b ill=%b",
                     result, branch_taken, illegal, expQ[0].res, expQ[0].taken, expQ[0].ill);
          end
          if (!seenFront) begin
            checks = checks + 1;
            if (cyc != expQ[0].acc + expQ[0].lat) begin
              errors = errors + 1;
              $display("[TB] FAIL latency actual=%0d required=%0d", cyc - expQ[0].acc, expQ[0].lat);
            end
            seenFront = 1;
          end
          if (out_ready) begin
            void'(expQ.pop_front());
            seenFront = 0;
          end
        end
      end else if (expQ.size() != 0 && !seenFront && cyc == expQ[0].acc + expQ[0].lat) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("[TB] FAIL late_result actual out_valid=0 required out_valid=1 at latency %0d", expQ[0].lat);
      end
      if (in_valid && in_ready) begin
        e = model(alu_op, funct3, funct7, op_a, op_b);
        e.acc = cyc;
        expQ.push_back(e);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Present one request from just after a rising edge; returns just after
  // the edge on which it was accepted, with in_valid dropped.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard    = 0;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL accept_timeout actual in_ready=0 required in_ready=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count falling edges until out_valid, bounded
  task automatic waitResult(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL result_timeout actual out_valid=0 required out_valid=1");
    end
  endtask

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[] = '{
    '{2'b10, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'h00000001},
    '{2'b10, 3'b001, 7'b0000000, 32'h00000003, 32'h00000021},
    '{2'b10, 3'b010, 7'b0000000, 32'hFFFFFFF0, 32'h00000002},
    '{2'b10, 3'b011, 7'b0000000, 32'hFFFFFFF0, 32'h00000002},
    '{2'b10, 3'b100, 7'b0000000, 32'hA5A5A5A5, 32'h0F0F0F0F},
    '{2'b10, 3'b101, 7'b0100000, 32'h80000010, 32'h0000001F},
    '{2'b10, 3'b110, 7'b0000000, 32'h12340000, 32'h00005678},
    '{2'b10, 3'b111, 7'b0000000, 32'hFF00FF00, 32'h0FF00FF0},
    '{2'b00, 3'b000, 7'b1111111, 32'h00000010, 32'hFFFFFFFF},
    '{2'b00, 3'b010, 7'b0000000, 32'h00000001, 32'hFFFFFFFF},
    '{2'b01, 3'b111, 7'b0100000, 32'h7FFFFFFF, 32'h00000001},
    '{2'b11, 3'b001, 7'b0000000, 32'h00000005, 32'h00000005},
    '{2'b11, 3'b101, 7'b0000000, 32'h80000000, 32'h7FFFFFFF},
    '{2'b11, 3'b111, 7'b0000000, 32'h80000000, 32'h7FFFFFFF},
    '{2'b11, 3'b000, 7'b0000000, 32'h0000ABCD, 32'h0000ABCD},
    '{2'b10, 3'b010, 7'b0100000, 32'h00000001, 32'h00000002},
    '{2'b11, 3'b011, 7'b0000000, 32'h00000001, 32'h00000002}
  };

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    errors = errors + 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    funct3    = 3'b000;
    funct7    = 7'b0000000;
    op_a      = '0;
    op_b      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    syncDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // SUB 5 - 7
    syncDrive();
    applyStimulus(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7);
    waitResult(n);
    checkOutput("sub_latency", n, 32'd1);
    checkOutput("sub_result", result, 32'hFFFFFFFE);
    checkOutput("sub_illegal", {31'd0, illegal}, 32'd0);

    // SRAI / SRLI selected by funct7[5]
    syncDrive();
    applyStimulus(2'b00, 3'b101, 7'b0100000, 32'h80000000, 32'd4);
    waitResult(n);
    checkOutput("srai_result", result, 32'hF8000000);
    syncDrive();
    applyStimulus(2'b00, 3'b101, 7'b0000000, 32'h80000000, 32'd4);
    waitResult(n);
    checkOutput("srli_result", result, 32'h08000000);

    // Signed vs unsigned branch compare
    syncDrive();
    applyStimulus(2'b11, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1);
    waitResult(n);
    checkOutput("blt_taken", {31'd0, branch_taken}, 32'd1);
    checkOutput("blt_result", result, 32'd0);
    syncDrive();
    applyStimulus(2'b11, 3'b110, 7'b0000000, 32'hFFFFFFFF, 32'd1);
    waitResult(n);
    checkOutput("bltu_taken", {31'd0, branch_taken}, 32'd0);

    // Illegal encodings
    syncDrive();
    applyStimulus(2'b11, 3'b010, 7'b0000000, 32'd3, 32'd3);
    waitResult(n);
    checkOutput("branch_f3_010_illegal", {31'd0, illegal}, 32'd1);
    checkOutput("branch_f3_010_taken", {31'd0, branch_taken}, 32'd0);
    syncDrive();
    applyStimulus(2'b10, 3'b000, 7'b0000010, 32'd3, 32'd4);
    waitResult(n);
    checkOutput("rtype_bad_f7_illegal", {31'd0, illegal}, 32'd1);
    checkOutput("rtype_bad_f7_result", result, 32'd0);
`ifndef ALU_EXEC_MEXT_EN
    syncDrive();
    applyStimulus(2'b10, 3'b000, 7'b0000001, 32'd6, 32'd7);
    waitResult(n);
    checkOutput("mul_disabled_latency", n, 32'd1);
    checkOutput("mul_disabled_illegal", {31'd0, illegal}, 32'd1);
`endif

    // Backpressure: result held for three cycles, then released
    syncDrive();
    out_ready = 1'b0;
    applyStimulus(2'b01, 3'b000, 7'b0000000, 32'd3, 32'd4);
    waitResult(n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_result", result, 32'd7);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    syncDrive();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream at one request per cycle
    syncDrive();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
    end
    repeat (3) @(negedge clk);

    // Reset while a result is being held
    syncDrive();
    out_ready = 1'b0;
    applyStimulus(2'b01, 3'b000, 7'b0000000, 32'd9, 32'd9);
    waitResult(n);
    syncDrive();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_hold_result", result, 32'd0);
    syncDrive();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_EXEC_MEXT_EN
    // Divide by zero and signed overflow
    syncDrive();
    applyStimulus(2'b10, 3'b100, 7'b0000001, 32'd7, 32'd0);
    waitResult(n);
    checkOutput("div0_latency", n, 32'd33);
    checkOutput("div0_result", result, 32'hFFFFFFFF);
    syncDrive();
    applyStimulus(2'b10, 3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF);
    waitResult(n);
    checkOutput("rem_ovf_latency", n, 32'd33);
    checkOutput("rem_ovf_result", result, 32'd0);
    syncDrive();
    applyStimulus(2'b10, 3'b000, 7'b0000001, 32'd6, 32'd7);
    waitResult(n);
    checkOutput("mul_result", result, 32'd42);
    syncDrive();
    applyStimulus(2'b10, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2);
    waitResult(n);
    checkOutput("div_neg_result", result, 32'hFFFFFFFD);
    syncDrive();
    applyStimulus(2'b10, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2);
    waitResult(n);
    checkOutput("rem_neg_result", result, 32'hFFFFFFFF);
    syncDrive();
    applyStimulus(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7);
    waitResult(n);
    syncDrive();
    applyStimulus(2'b10, 3'b111, 7'b0000001, 32'd7, 32'd0);
    waitResult(n);
    checkOutput("remu0_result", result, 32'd7);
    syncDrive();
    applyStimulus(2'b10, 3'b001, 7'b0000001, 32'd6, 32'd7);
    waitResult(n);
    checkOutput("mext_f3_001_latency", n, 32'd1);
    checkOutput("mext_f3_001_illegal", {31'd0, illegal}, 32'd1);

    // Held iterative result
    syncDrive();
    out_ready = 1'b0;
    applyStimulus(2'b10, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitResult(n);
    repeat (2) @(negedge clk);
    checkOutput("iter_hold_result", result, 32'd1);
    checkOutput("iter_hold_in_ready", {31'd0, in_ready}, 32'd0);
    syncDrive();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during a multiply aborts it
    syncDrive();
    applyStimulus(2'b10, 3'b000, 7'b0000001, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    syncDrive();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < XLEN + 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checkOutput("abort_no_result", n, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
